// File: rtl/point_validate_if.sv
// Request/result bundle between the point source and the validation stage.
// Coordinates and curve constants go in; the verdict and the latched point come out.
interface point_validate_if #(
  parameter int WIDTH = 256
);
  logic             i_start;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_p;
  logic [WIDTH-1:0] i_x;
  logic [WIDTH-1:0] i_y;
  logic             o_busy;
  logic             o_finished;
  logic             o_on_curve;
  logic             o_infinity;
  logic             o_range_err;
  logic [WIDTH-1:0] o_x;
  logic [WIDTH-1:0] o_y;

  modport master (
    output i_start, i_mode, i_a, i_b, i_p, i_x, i_y,
    input  o_busy, o_finished, o_on_curve, o_infinity, o_range_err, o_x, o_y
  );

  modport slave (
    input  i_start, i_mode, i_a, i_b, i_p, i_x, i_y,
    output o_busy, o_finished, o_on_curve, o_infinity, o_range_err, o_x, o_y
  );
endinterface

// File: rtl/point_validate.sv
// Qualifies an affine point against y^2 = x^3 + a*x + b mod p before it reaches the
// scalar-multiplication core, using a private bit-serial interleaved modular multiplier.
module point_validate #(
  parameter int WIDTH = 256
) (
  input  logic            i_clk,
  input  logic            i_rst,
  point_validate_if.slave bus
);

  localparam int AW = WIDTH + 2;

  localparam logic [1:0] MODE_256 = 2'b00;
  localparam logic [1:0] MODE_128 = 2'b01;
  localparam logic [1:0] MODE_64  = 2'b10;
  localparam logic [1:0] MODE_32  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_SUM1  = 3'd3,
    ST_SUM2  = 3'd4,
    ST_CMP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t           state_r;
  state_t           next_state_s;

  logic [1:0]       mode_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] t1_r;
  logic [WIDTH-1:0] t2_r;
  logic [WIDTH-1:0] t3_r;
  logic [WIDTH-1:0] s_r;
  logic [AW-1:0]    acc_r;
  logic [7:0]       bit_r;
  logic [1:0]       op_r;
  logic             busy_r;
  logic             finished_r;
  logic             on_curve_r;
  logic             infinity_r;
  logic             range_err_r;

  logic [8:0]       shift_s;
  logic [7:0]       top_bit_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] am_s;
  logic [WIDTH-1:0] bm_s;
  logic [WIDTH-1:0] pm_s;
  logic [WIDTH-1:0] xm_s;
  logic [WIDTH-1:0] ym_s;
  logic [AW-1:0]    pw_s;
  logic             inf_s;
  logic             range_s;
  logic [WIDTH-1:0] mcand_s;
  logic [WIDTH-1:0] mplier_s;
  logic [AW-1:0]    dbl_s;
  logic [AW-1:0]    red1_s;
  logic [AW-1:0]    add_s;
  logic [AW-1:0]    acc_next_s;
  logic             last_bit_s;
  logic [AW-1:0]    sum1_s;
  logic [AW-1:0]    sum1_red_s;
  logic [AW-1:0]    sum2_s;
  logic [AW-1:0]    sum2_red_s;

  // Active width K: mask of the low K bits and index of the first multiplier bit.
  always_comb begin
    shift_s   = 9'd0;
    top_bit_s = 8'd255;
    case (mode_r)
      MODE_256: begin
        shift_s   = 9'(WIDTH - 256);
        top_bit_s = 8'd255;
      end
      MODE_128: begin
        shift_s   = 9'(WIDTH - 128);
        top_bit_s = 8'd127;
      end
      MODE_64: begin
        shift_s   = 9'(WIDTH - 64);
        top_bit_s = 8'd63;
      end
      MODE_32: begin
        shift_s   = 9'(WIDTH - 32);
        top_bit_s = 8'd31;
      end
      default: begin
        shift_s   = 9'd0;
        top_bit_s = 8'd255;
      end
    endcase
    mask_s = {WIDTH{1'b1}} >> shift_s;
  end

  // Masked operands and the CHECK-state classification.
  always_comb begin
    am_s    = a_r & mask_s;
    bm_s    = b_r & mask_s;
    pm_s    = p_r & mask_s;
    xm_s    = x_r & mask_s;
    ym_s    = y_r & mask_s;
    pw_s    = {2'b00, pm_s};
    inf_s   = (&x_r) & (&y_r);
    range_s = (xm_s >= pm_s) || (ym_s >= pm_s);
  end

  // Operand routing for the four products.
  always_comb begin
    mcand_s  = {WIDTH{1'b0}};
    mplier_s = {WIDTH{1'b0}};
    case (op_r)
      2'd0: begin
        mcand_s  = xm_s;
        mplier_s = xm_s;
      end
      2'd1: begin
        mcand_s  = t1_r;
        mplier_s = xm_s;
      end
      2'd2: begin
        mcand_s  = am_s;
        mplier_s = xm_s;
      end
      2'd3: begin
        mcand_s  = ym_s;
        mplier_s = ym_s;
      end
      default: begin
        mcand_s  = {WIDTH{1'b0}};
        mplier_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // One interleaved step: double-and-reduce, then conditional add-and-reduce.
  always_comb begin
    dbl_s      = acc_r << 1;
    red1_s     = dbl_s;
    add_s      = {AW{1'b0}};
    acc_next_s = {AW{1'b0}};
    if (dbl_s >= pw_s) begin
      red1_s = dbl_s - pw_s;
    end else begin
      red1_s = dbl_s;
    end
    if (mplier_s[bit_r]) begin
      add_s = red1_s + {2'b00, mcand_s};
      if (add_s >= pw_s) begin
        acc_next_s = add_s - pw_s;
      end else begin
        acc_next_s = add_s;
      end
    end else begin
      add_s      = {AW{1'b0}};
      acc_next_s = red1_s;
    end
    last_bit_s = (bit_r == 8'd0);
  end

  // Right-hand-side accumulation: t1 + t2, then + b, each with one conditional subtract.
  always_comb begin
    sum1_s     = {2'b00, t1_r} + {2'b00, t2_r};
    sum1_red_s = (sum1_s >= pw_s) ? (sum1_s - pw_s) : sum1_s;
    sum2_s     = {2'b00, s_r} + {2'b00, bm_s};
    sum2_red_s = (sum2_s >= pw_s) ? (sum2_s - pw_s) : sum2_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (inf_s || range_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      ST_MUL: begin
        if (last_bit_s && (op_r == 2'd3)) begin
          next_state_s = ST_SUM1;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      ST_SUM1: next_state_s = ST_SUM2;
      ST_SUM2: next_state_s = ST_CMP;
      ST_CMP:  next_state_s = ST_DONE;
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register with registered busy/finished derived from the upcoming state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      finished_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      busy_r     <= (next_state_s != ST_IDLE);
      finished_r <= (next_state_s == ST_DONE);
    end
  end

  // Operand latching, multiplier sequencing and verdict flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_r      <= 2'b00;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      p_r         <= {WIDTH{1'b0}};
      x_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      t1_r        <= {WIDTH{1'b0}};
      t2_r        <= {WIDTH{1'b0}};
      t3_r        <= {WIDTH{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      acc_r       <= {AW{1'b0}};
      bit_r       <= 8'd0;
      op_r        <= 2'd0;
      on_curve_r  <= 1'b0;
      infinity_r  <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_start) begin
            mode_r      <= bus.i_mode;
            a_r         <= bus.i_a;
            b_r         <= bus.i_b;
            p_r         <= bus.i_p;
            x_r         <= bus.i_x;
            y_r         <= bus.i_y;
            on_curve_r  <= 1'b0;
            infinity_r  <= 1'b0;
            range_err_r <= 1'b0;
          end
        end
        ST_CHECK: begin
          acc_r <= {AW{1'b0}};
          bit_r <= top_bit_s;
          op_r  <= 2'd0;
          if (inf_s) begin
            infinity_r <= 1'b1;
          end else if (range_s) begin
            range_err_r <= 1'b1;
          end
        end
        ST_MUL: begin
          if (last_bit_s) begin
            // acc is cleared here so the next product starts without a gap cycle.
            case (op_r)
              2'd0:    t1_r <= acc_next_s[WIDTH-1:0];
              2'd1:    t1_r <= acc_next_s[WIDTH-1:0];
              2'd2:    t2_r <= acc_next_s[WIDTH-1:0];
              2'd3:    t3_r <= acc_next_s[WIDTH-1:0];
              default: t3_r <= acc_next_s[WIDTH-1:0];
            endcase
            acc_r <= {AW{1'b0}};
            bit_r <= top_bit_s;
            op_r  <= op_r + 2'd1;
          end else begin
            acc_r <= acc_next_s;
            bit_r <= bit_r - 8'd1;
          end
        end
        ST_SUM1: s_r <= sum1_red_s[WIDTH-1:0];
        ST_SUM2: s_r <= sum2_red_s[WIDTH-1:0];
        ST_CMP:  on_curve_r <= (s_r == t3_r);
        default: begin
        end
      endcase
    end
  end

  assign bus.o_busy      = busy_r;
  assign bus.o_finished  = finished_r;
  assign bus.o_on_curve  = on_curve_r;
  assign bus.o_infinity  = infinity_r;
  assign bus.o_range_err = range_err_r;
  assign bus.o_x         = x_r;
  assign bus.o_y         = y_r;

endmodule

// File: tb/tb_point_validate.sv
// Directed bench for point_validate: latency, verdict flags, masking, ignored starts,
// back-to-back acceptance and mid-operation reset.
module tb_point_validate;

  localparam logic [1:0] M256 = 2'b00;
  localparam logic [1:0] M64  = 2'b10;
  localparam logic [1:0] M32  = 2'b11;

  localparam logic [255:0] SP  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] SGX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] SGY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  point_validate_if #(.WIDTH(256)) pif ();

  point_validate #(.WIDTH(256)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (pif)
  );

  // flags as {on_curve, infinity, range_err}
  function automatic logic [2:0] flags();
    return {pif.o_on_curve, pif.o_infinity, pif.o_range_err};
  endfunction

  // Present one start pulse; returns at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] m, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] p, input logic [255:0] x, input logic [255:0] y);
    @(negedge clk);
    pif.i_mode  = m;
    pif.i_a     = a;
    pif.i_b     = b;
    pif.i_p     = p;
    pif.i_x     = x;
    pif.i_y     = y;
    pif.i_start = 1'b1;
    @(negedge clk);
    pif.i_start = 1'b0;
  endtask

  // Count cycles from c0 until o_finished; lat = -1 if the budget runs out.
  task automatic wait_done(input int c0, input int budget, output int lat);
    int c;
    c   = c0;
    lat = -1;
    while (c <= budget) begin
      if (pif.o_finished) begin
        lat = c;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pif.i_start = 1'b0;
    pif.i_mode  = 2'b00;
    pif.i_a = '0; pif.i_b = '0; pif.i_p = '0; pif.i_x = '0; pif.i_y = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({pif.o_busy, pif.o_finished, flags()} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000", {pif.o_busy, pif.o_finished, flags()});
    end
    total++;
    if ({pif.o_x, pif.o_y} !== 512'd0) begin
      bad++;
      $display("FAIL reset_xy got x=%h y=%h want 0", pif.o_x, pif.o_y);
    end
    rst = 1'b0;
  endtask

  task automatic test_on_curve();
    int lat;
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd6);
    total++;
    if ({pif.o_busy, pif.o_finished} !== 2'b10) begin
      bad++;
      $display("FAIL busy_cycle1 got=%b want=10", {pif.o_busy, pif.o_finished});
    end
    wait_done(1, 1200, lat);
    total++;
    if (lat !== 133) begin bad++; $display("FAIL oncurve_latency got=%0d want=133", lat); end
    total++;
    if (flags() !== 3'b100) begin bad++; $display("FAIL oncurve_flags got=%b want=100", flags()); end
    total++;
    if (pif.o_x !== 256'd3 || pif.o_y !== 256'd6) begin
      bad++;
      $display("FAIL oncurve_xy got x=%0d y=%0d want 3 6", pif.o_x, pif.o_y);
    end
    @(negedge clk);
    total++;
    if ({pif.o_busy, pif.o_finished, flags()} !== 5'b00100) begin
      bad++;
      $display("FAIL after_done got=%b want=00100", {pif.o_busy, pif.o_finished, flags()});
    end
  endtask

  task automatic test_off_curve();
    int lat;
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd7);
    wait_done(1, 1200, lat);
    total++;
    if (lat !== 133) begin bad++; $display("FAIL offcurve_latency got=%0d want=133", lat); end
    total++;
    if (flags() !== 3'b000) begin bad++; $display("FAIL offcurve_flags got=%b want=000", flags()); end
  endtask

  task automatic test_range_infinity();
    int lat;
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd97, 256'd6);
    wait_done(1, 50, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL range_x_latency got=%0d want=2", lat); end
    total++;
    if (flags() !== 3'b001) begin bad++; $display("FAIL range_x_flags got=%b want=001", flags()); end
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd100);
    wait_done(1, 50, lat);
    total++;
    if (lat !== 2 || flags() !== 3'b001) begin
      bad++;
      $display("FAIL range_y got lat=%0d flags=%b want 2 001", lat, flags());
    end
    start_op(M32, 256'd2, 256'd3, 256'd97, {256{1'b1}}, {256{1'b1}});
    wait_done(1, 50, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL inf_latency got=%0d want=2", lat); end
    total++;
    if (flags() !== 3'b010) begin bad++; $display("FAIL inf_flags got=%b want=010", flags()); end
  endtask

  task automatic test_secp256k1();
    int lat;
    start_op(M256, 256'd0, 256'd7, SP, SGX, SGY);
    wait_done(1, 1100, lat);
    total++;
    if (lat !== 1029) begin bad++; $display("FAIL secp_latency got=%0d want=1029", lat); end
    total++;
    if (flags() !== 3'b100) begin bad++; $display("FAIL secp_g_flags got=%b want=100", flags()); end
    start_op(M256, 256'd0, 256'd7, SP, SGX, SGY + 256'd1);
    wait_done(1, 1100, lat);
    total++;
    if (lat !== 1029 || flags() !== 3'b000) begin
      bad++;
      $display("FAIL secp_gy1 got lat=%0d flags=%b want 1029 000", lat, flags());
    end
  endtask

  task automatic test_masking();
    int lat;
    logic [255:0] xw;
    xw = 256'hABCD_0000_0000_0000_0003;
    start_op(M32, 256'd2, 256'd3, 256'd97, xw, 256'd6);
    wait_done(1, 1200, lat);
    total++;
    if (lat !== 133 || flags() !== 3'b100) begin
      bad++;
      $display("FAIL mask32 got lat=%0d flags=%b want 133 100", lat, flags());
    end
    total++;
    if (pif.o_x !== xw) begin bad++; $display("FAIL mask_ox got=%h want=%h", pif.o_x, xw); end
    start_op(M64, 256'd2, 256'd3, 256'd97, 256'd3, 256'd6);
    wait_done(1, 1200, lat);
    total++;
    if (lat !== 261 || flags() !== 3'b100) begin
      bad++;
      $display("FAIL mode64 got lat=%0d flags=%b want 261 100", lat, flags());
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd6);
    repeat (49) @(negedge clk);
    pif.i_x     = 256'd3;
    pif.i_y     = 256'd7;
    pif.i_start = 1'b1;
    @(negedge clk);
    pif.i_start = 1'b0;
    wait_done(51, 1200, lat);
    total++;
    if (lat !== 133 || flags() !== 3'b100) begin
      bad++;
      $display("FAIL ignored_start got lat=%0d flags=%b want 133 100", lat, flags());
    end
    total++;
    if (pif.o_y !== 256'd6) begin bad++; $display("FAIL ignored_start_y got=%0d want=6", pif.o_y); end
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd7);
    wait_done(1, 1200, lat);
    total++;
    if (lat !== 133 || flags() !== 3'b000 || pif.o_y !== 256'd7) begin
      bad++;
      $display("FAIL b2b got lat=%0d flags=%b y=%0d want 133 000 7", lat, flags(), pif.o_y);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd6);
    repeat (69) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({pif.o_busy, pif.o_finished, flags()} !== 5'b00000 || {pif.o_x, pif.o_y} !== 512'd0) begin
      bad++;
      $display("FAIL abort_outputs got ctrl=%b x=%0d y=%0d want 0",
               {pif.o_busy, pif.o_finished, flags()}, pif.o_x, pif.o_y);
    end
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (pif.o_finished || pif.o_busy) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_finish got=%0d want=0", seen); end
    start_op(M32, 256'd2, 256'd3, 256'd97, 256'd3, 256'd6);
    wait_done(1, 1200, lat);
    total++;
    if (lat !== 133 || flags() !== 3'b100) begin
      bad++;
      $display("FAIL after_abort got lat=%0d flags=%b want 133 100", lat, flags());
    end
  endtask

  initial begin
    test_reset();
    test_on_curve();
    test_off_curve();
    test_range_infinity();
    test_secp256k1();
    test_masking();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/point_validate.md
Name: point_validate

Overview:
- Input-qualification stage that sits directly upstream of the scalar-multiplication core.
- Checks that an affine base point (x, y) lies on y^2 = x^3 + a*x + b mod p before it is handed to the core.
- Also detects the all-ones point-at-infinity encoding and out-of-range coordinates.
- Uses a self-contained bit-serial interleaved modular multiplier, so it does not share the core's ModuloProduct.

Parameters:
- WIDTH, 256 (`MAX_BITS): coordinate/modulus width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  start request; sampled only in IDLE.
- i_mode  in  2  `BITS256/`BITS128/`BITS64/`BITS32; selects active width K = 256/128/64/32.
- i_a  in  WIDTH  curve coefficient a; must be < p.
- i_b  in  WIDTH  curve coefficient b; must be < p.
- i_p  in  WIDTH  prime modulus; odd, > 2.
- i_x  in  WIDTH  point x.
- i_y  in  WIDTH  point y.
- o_busy  out  1  high from the cycle after start acceptance until DONE, inclusive.
- o_finished  out  1  one-cycle completion pulse.
- o_on_curve  out  1  point satisfies the curve equation; valid while o_finished=1 and held until next start.
- o_infinity  out  1  input was the infinity encoding (all WIDTH bits of x and y are 1).
- o_range_err  out  1  x >= p or y >= p.
- o_x  out  WIDTH  latched x, forwarded to the core.
- o_y  out  WIDTH  latched y, forwarded to the core.

Behaviour:
- Reset: state IDLE; all outputs 0. Reset mid-operation aborts immediately and produces no o_finished pulse.
- IDLE:
  - On i_start=1, latch i_mode, a, b, p, x, y.
  - Clear o_on_curve, o_infinity, o_range_err.
  - Go to CHECK.
  - i_start is ignored in every other state.
- Masking: all arithmetic uses the low K bits of the latched operands; upper bits are treated as 0. The infinity test uses the full unmasked WIDTH bits.
- CHECK (1 cycle):
  - Infinity encoding: set o_infinity=1, go to DONE.
  - Else if x >= p or y >= p (masked compare): set o_range_err=1, go to DONE.
  - Else go to MUL with op=0.
- MUL: four back-to-back products, K cycles each, with no idle cycle between them.
  - op0: t1 = x*x
  - op1: t1 = t1*x
  - op2: t2 = a*x
  - op3: t3 = y*y
- Multiplier step: scan multiplier bits MSB (bit K-1) to LSB, one bit per cycle, on a WIDTH+2-bit accumulator.
  - acc = 2*acc; if acc >= p then acc -= p.
  - If the multiplier bit is 1: acc += multiplicand; if acc >= p then acc -= p.
  - acc is cleared at the start of each op.
  - Result is available at the end of cycle K of that op.
- SUM1: s = t1 + t2 mod p (single conditional subtract).
- SUM2: s = s + b mod p.
- CMP: o_on_curve = (s == t3).
- DONE: o_finished=1 for exactly this cycle; o_busy=1; next state IDLE.
- Latency, counting the edge that samples i_start as cycle 0:
  - Normal path: o_finished is high in cycle 4K+5.
  - Infinity or range-error path: o_finished is high in cycle 2.
- Outputs:
  - o_x and o_y update at start acceptance and hold until the next accepted start.
  - Flags hold after DONE until the next accepted start.
- Back-to-back operation: a start presented in the cycle after DONE (state IDLE) is accepted.
- Exactly one of {o_on_curve, o_infinity, o_range_err} is 1 at o_finished, or none if the point is off-curve.

Test Plan:
1. Mode `BITS32, p=97, a=2, b=3, x=3, y=6, i_start pulse -> o_finished in cycle 133 (4*32+5), o_on_curve=1, o_range_err=0, o_infinity=0, o_x=3, o_y=6.
2. Same curve, x=3, y=7 -> o_finished in cycle 133, o_on_curve=0, other flags 0.
3. Same curve, x=97, y=6 -> o_finished in cycle 2, o_range_err=1, o_on_curve=0. Repeat with x and y all ones -> o_infinity=1, o_range_err=0.
4. Mode `BITS256, secp256k1 (a=0, b=7) with generator G -> o_finished in cycle 1029, o_on_curve=1. With G.y+1 -> o_on_curve=0.
5. Start scenario 1, reassert i_start at cycle 50 with scenario 2 data -> ignored; result is still on-curve for (3,6) at cycle 133. Then start scenario 2 in the cycle after DONE -> accepted, o_on_curve=0.
6. Assert i_rst at cycle 70 of scenario 1 -> next cycle state IDLE, all outputs 0, no o_finished pulse. A fresh start afterwards gives the scenario 1 result with normal latency.
